// File: rtl/antic_dma_arbiter.sv
// antic_dma_arbiter: shares ANTIC's single memory port between the DL, MSR,
// CHR and PM fetch engines and DRAM refresh. Each access is a fixed
// three-cycle IDLE -> ADDR -> DATA sequence with registered bus outputs.
module antic_dma_arbiter #(
  parameter int unsigned REF_PERIOD = 12
) (
  input  logic        Fphi0,
  input  logic        rst_L,
  input  logic [7:0]  DMACTL,
  input  logic        hblank,
  input  logic        req_dl,
  input  logic [15:0] addr_dl,
  input  logic        req_msr,
  input  logic [15:0] addr_msr,
  input  logic        req_chr,
  input  logic [15:0] addr_chr,
  input  logic        req_pm,
  input  logic [15:0] addr_pm,
  input  logic [7:0]  DB,
  output logic [15:0] address,
  output logic [7:0]  data,
  output logic [3:0]  ack,
  output logic [4:0]  gnt,
  output logic        halt_L,
  output logic        REF_L,
  output logic        busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NREQ   = 5;

  // gnt bit positions: {ref,pm,chr,msr,dl}
  localparam int unsigned G_DL  = 0;
  localparam int unsigned G_MSR = 1;
  localparam int unsigned G_CHR = 2;
  localparam int unsigned G_PM  = 3;
  localparam int unsigned G_REF = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state_q,       state_d;
  logic [ADDR_W-1:0] address_q,     address_d;
  logic [DATA_W-1:0] data_q,        data_d;
  logic [3:0]        ack_q,         ack_d;
  logic [NREQ-1:0]   gnt_q,         gnt_d;
  logic              halt_l_q,      halt_l_d;
  logic              ref_l_q,       ref_l_d;
  logic              busy_q,        busy_d;
  logic [CNT_W-1:0]  ref_cnt_q,     ref_cnt_d;
  logic              ref_pending_q, ref_pending_d;
  logic [7:0]        ref_row_q,     ref_row_d;

  logic              dl_en, pf_en, pm_en;
  logic              ref_wrap;
  logic              ref_grant;
  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   winner;
  logic [ADDR_W-1:0] winner_addr;
  logic              dmactl_unused;

  assign dmactl_unused = ^{DMACTL[7:6], DMACTL[4]};

  assign address = address_q;
  assign data    = data_q;
  assign ack     = ack_q;
  assign gnt     = gnt_q;
  assign halt_L  = halt_l_q;
  assign REF_L   = ref_l_q;
  assign busy    = busy_q;

  assign dl_en    = DMACTL[5];
  assign pf_en    = (DMACTL[1:0] != 2'b00);
  assign pm_en    = (DMACTL[3] | DMACTL[2]) & hblank;
  assign ref_wrap = (ref_cnt_q == CNT_W'(REF_PERIOD - 1));

  // Eligible requesters, excluding any whose ack is currently showing
  always_comb begin
    cand        = '0;
    cand[G_DL]  = req_dl  & dl_en & ~ack_q[G_DL];
    cand[G_MSR] = req_msr & pf_en & ~ack_q[G_MSR];
    cand[G_CHR] = req_chr & pf_en & ~ack_q[G_CHR];
    cand[G_PM]  = req_pm  & pm_en & ~ack_q[G_PM];
    cand[G_REF] = ref_pending_q;
  end

  // Fixed priority pick REF > PM > DL > MSR > CHR, with the winner's address
  always_comb begin
    winner      = '0;
    winner_addr = '0;
    if (cand[G_REF]) begin
      winner[G_REF] = 1'b1;
      winner_addr   = {8'h00, ref_row_q};
    end else if (cand[G_PM]) begin
      winner[G_PM]  = 1'b1;
      winner_addr   = addr_pm;
    end else if (cand[G_DL]) begin
      winner[G_DL]  = 1'b1;
      winner_addr   = addr_dl;
    end else if (cand[G_MSR]) begin
      winner[G_MSR] = 1'b1;
      winner_addr   = addr_msr;
    end else if (cand[G_CHR]) begin
      winner[G_CHR] = 1'b1;
      winner_addr   = addr_chr;
    end
  end

  // Next-state and output logic for the access sequencer and refresh timer
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    data_d        = data_q;
    ack_d         = ack_q;
    gnt_d         = gnt_q;
    halt_l_d      = halt_l_q;
    ref_l_d       = ref_l_q;
    busy_d        = busy_q;
    ref_row_d     = ref_row_q;
    ref_grant     = 1'b0;
    ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + CNT_W'(1);
    ref_pending_d = ref_pending_q;

    case (state_q)
      IDLE: begin
        ack_d = '0;
        gnt_d = '0;
        if (winner != '0) begin
          state_d   = ADDR;
          gnt_d     = winner;
          halt_l_d  = 1'b0;
          busy_d    = 1'b1;
          address_d = winner_addr;
          if (winner[G_REF]) begin
            ref_l_d   = 1'b0;
            ref_grant = 1'b1;
          end
        end
      end
      ADDR: begin
        state_d = DATA;
      end
      DATA: begin
        state_d  = IDLE;
        halt_l_d = 1'b1;
        ref_l_d  = 1'b1;
        gnt_d    = '0;
        busy_d   = 1'b0;
        if (gnt_q[G_REF]) begin
          ref_row_d = ref_row_q + 8'd1;
        end else begin
          data_d = DB;
          ack_d  = gnt_q[3:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A wrap on the grant edge re-arms the request rather than being lost
    if (ref_wrap) begin
      ref_pending_d = 1'b1;
    end else if (ref_grant) begin
      ref_pending_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Fphi0) begin
    if (!rst_L) begin
      state_q       <= IDLE;
      address_q     <= '0;
      data_q        <= '0;
      ack_q         <= '0;
      gnt_q         <= '0;
      halt_l_q      <= 1'b1;
      ref_l_q       <= 1'b1;
      busy_q        <= 1'b0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      data_q        <= data_d;
      ack_q         <= ack_d;
      gnt_q         <= gnt_d;
      halt_l_q      <= halt_l_d;
      ref_l_q       <= ref_l_d;
      busy_q        <= busy_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_row_q     <= ref_row_d;
    end
  end

endmodule

// File: doc/antic_dma_arbiter.md
Name: antic_dma_arbiter

Overview:
- Sequences and shares ANTIC's single memory port between its DMA requesters: display-list fetch (DL), memory-scan data fetch (MSR), character-set fetch (CHR), player/missile fetch (PM), and DRAM refresh (REF).
- Sits between the ANTIC fetch logic and the system address and data bus.
- Owns the `address` bus register, the `halt_L` and `REF_L` strobes, and the captured data byte.
- Requesters issue a request with an address and get a one-cycle ack with the data.

Parameters:
- REF_PERIOD, 12, Fphi0 cycles between refresh requests; legal range 4..255.

Ports:
- Fphi0 input 1: single system clock; every flop is clocked on its rising edge.
- rst_L input 1: synchronous, active-low reset.
- DMACTL input 8: DMA control register.
- hblank input 1: horizontal blank window.
- req_dl input 1 / addr_dl input 16: display-list request and address.
- req_msr input 1 / addr_msr input 16: memory-scan request and address.
- req_chr input 1 / addr_chr input 16: character-set request and address.
- req_pm input 1 / addr_pm input 16: player/missile request and address.
- DB input 8: system data bus.
- address output 16: registered memory address.
- data output 8: byte captured from DB on a completed access.
- ack output 4: one-hot completion pulse, {pm,chr,msr,dl} = bits [3:0].
- gnt output 5: one-hot owner of the current access, {ref,pm,chr,msr,dl}.
- halt_L output 1: low while any access (including refresh) is in progress.
- REF_L output 1: low during refresh accesses.
- busy output 1: high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- **Reset** (rst_L=0 at a rising edge, including in the middle of an access):
  - state=IDLE; address=0, data=0, ack=0, gnt=0, halt_L=1, REF_L=1, busy=0.
  - ref_cnt=0, ref_pending=0, ref_row=0.
  - Any access in flight is abandoned with no ack.
- **Enable gating from DMACTL:**
  - DL eligible iff DMACTL[5]=1.
  - MSR and CHR eligible iff DMACTL[1:0]!=0.
  - PM eligible iff (DMACTL[3]|DMACTL[2])=1 and hblank=1.
  - An ineligible request stays pending: it is never acked or dropped by the arbiter.
- **Refresh timer:**
  - ref_cnt increments every cycle and wraps from REF_PERIOD-1 to 0.
  - On wrap, ref_pending<=1.
  - A refresh grant clears ref_pending. If wrap and grant fall on the same edge, ref_pending stays 1 (the new request wins).
  - A wrap while already pending is lost; there is no queueing.
- **Priority** (fixed, evaluated only in IDLE): REF > PM > DL > MSR > CHR.
- **Re-grant mask:** a requester whose ack bit is currently 1 is excluded that cycle, so a requester that drops req on seeing ack is never double-served.
- **FSM** (IDLE, ADDR, DATA):
  - IDLE, winner exists:
    - next=ADDR; gnt<=winner; halt_L<=0; busy<=1.
    - address<=winner address.
    - If the winner is REF: address<={8'h00, ref_row}, REF_L<=0.
    - ack<=0.
  - IDLE, no winner: stay in IDLE; gnt=0; ack<=0.
  - ADDR: next=DATA; all outputs hold.
  - DATA: next=IDLE; halt_L<=1; REF_L<=1; gnt<=0; busy<=0.
    - Non-REF access: data<=DB and ack bit of the owner <=1 for exactly one cycle.
    - REF access: data unchanged, no ack, ref_row<=ref_row+1 (8-bit wrap, 255->0).
- **Timing:**
  - A request sampled in IDLE at edge k gets its ack high after edge k+2.
  - The earliest next grant is at edge k+3, so back-to-back accesses take 3 cycles each.
- **Requester contract:**
  - Hold req and addr stable from assertion until ack is seen.
  - Drop req by the edge after ack.
  - An address change while in ADDR or DATA has no effect, because address was latched at the grant.
- **Withdrawal:** deasserting req after a grant does not cancel the access; the ack is still issued.
- **DMACTL changes:** a change mid-access does not abort that access; it only affects the next IDLE decision.

Test Plan:
1. **Single DL fetch.** Reset, DMACTL=8'h20, req_dl=1 with addr_dl=16'h3C00, DB=8'h42.
   - address=16'h3C00 and halt_L=0 after grant edge k.
   - ack=4'b0001 and data=8'h42 after edge k+2, then halt_L=1.
2. **Priority and mask.** DMACTL=8'h2E, hblank=1, req_pm, req_dl, req_msr and req_chr all asserted at once, each dropped on its ack.
   - gnt sequence is PM, DL, MSR, CHR, one grant every 3 cycles.
   - No requester is acked twice.
3. **Enable gating.**
   - DMACTL=8'h00 with all req high: no grant for 50 cycles except REF.
   - Set DMACTL[5]=1: DL is granted at the next IDLE.
   - PM with hblank=0 is never granted; setting hblank=1 grants it.
4. **Refresh.**
   - Idle bus, REF_PERIOD=12: a REF grant every 12 cycles.
   - REF_L is low for 2 cycles, address runs 16'h0000, 16'h0001, and so on.
   - ref_row wraps 255->0.
   - With DL held continuously requested, REF still preempts at the next IDLE after each wrap.
5. **Reset mid-access.** Drive rst_L=0 while in DATA with the MSR grant active.
   - At the next edge: ack=0, gnt=0, halt_L=1, REF_L=1, address=0, data=0.
   - No ack is issued after rst_L returns to 1.
6. **Withdrawal and address change.** Drop req_chr and change addr_chr one cycle after the grant.
   - address keeps the originally latched value.
   - ack[2] pulses once; no further CHR grant follows.
